// File: rtl/conv_window_sequencer.sv
// Walks every valid KxK window of a binary ifmap, feeding one tap per cycle to an
// external MAC PE and presenting each finished window sum on a valid/ready port.
module conv_window_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int PSUM_DATA_WIDTH = 12,
  parameter int IMG_W           = 4,
  parameter int IMG_H           = 4,
  parameter int K               = 3,
  localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int TW = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      bias,
  output logic [AW-1:0]              ifmap_addr,
  input  logic                       ifmap_data,
  output logic [TW-1:0]              weight_addr,
  input  logic [DATA_WIDTH-1:0]      weight_data,
  output logic [PSUM_DATA_WIDTH-1:0] pe_inpsum,
  output logic [DATA_WIDTH-1:0]      pe_weight,
  output logic [DATA_WIDTH-1:0]      pe_bias,
  output logic                       pe_infmap,
  input  logic [PSUM_DATA_WIDTH-1:0] pe_outpsum,
  output logic [PSUM_DATA_WIDTH-1:0] out_psum,
  output logic [RW-1:0]              out_row,
  output logic [CW-1:0]              out_col,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 dbg_state
);

  // Output handshake: out_psum/out_row/out_col are valid while out_valid is high and
  // stay frozen until the cycle in which out_ready is also high; that cycle transfers.
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        bias_q, bias_d;
  logic [PSUM_DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [RW-1:0]                row_q, row_d;
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                ky_q, ky_d;
  logic [CW-1:0]                kx_q, kx_d;
  logic [TW-1:0]                tap_q, tap_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         first_q, first_d;
  logic                         last_tap, last_kx, last_col, last_row;

  assign last_tap = (tap_q == TW'(K * K - 1));
  assign last_kx  = (kx_q == CW'(K - 1));
  assign last_col = (col_q == CW'(IMG_W - K));
  assign last_row = (row_q == RW'(IMG_H - K));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bias_q     <= '0;
      acc_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      tap_q      <= '0;
      rd_valid_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bias_q     <= bias_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      tap_q      <= tap_d;
      rd_valid_q <= rd_valid_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bias_d     = bias_q;
    acc_d      = acc_q;
    row_d      = row_q;
    col_d      = col_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    tap_d      = tap_q;
    rd_valid_d = 1'b0;
    first_d    = 1'b0;

    // Memory data lags the address by one cycle, so the PE result for the tap
    // issued last cycle lands here (covers both RUN and DRAIN).
    if (rd_valid_q) acc_d = pe_outpsum;

    case (state_q)
      IDLE: begin
        if (start) begin
          bias_d  = bias;
          row_d   = '0;
          col_d   = '0;
          ky_d    = '0;
          kx_d    = '0;
          tap_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rd_valid_d = 1'b1;
        first_d    = (tap_q == '0);
        if (last_tap) begin
          tap_d   = '0;
          ky_d    = '0;
          kx_d    = '0;
          state_d = DRAIN;
        end else begin
          tap_d = tap_q + TW'(1);
          if (last_kx) begin
            kx_d = '0;
            ky_d = ky_q + RW'(1);
          end else begin
            kx_d = kx_q + CW'(1);
          end
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (last_col && last_row) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifmap_addr  = '0;
    weight_addr = '0;
    if (state_q == RUN) begin
      ifmap_addr  = (AW'(row_q) + AW'(ky_q)) * AW'(IMG_W) + AW'(col_q) + AW'(kx_q);
      weight_addr = tap_q;
    end
  end

  // Tap 0 of each window restarts the sum from zero and is the only tap carrying bias.
  assign pe_bias   = first_q ? bias_q : '0;
  assign pe_inpsum = first_q ? '0 : acc_q;
  assign pe_weight = weight_data;
  assign pe_infmap = ifmap_data;

  assign out_psum  = acc_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: two sequencer instances (default and 10-bit psum) driven against
// synchronous-read memory models and a behavioural binary MAC PE.
module tb_conv_window_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Shared stimulus
  logic       start = 1'b0;
  logic       start_w = 1'b0;
  logic [7:0] bias = '0;
  logic       out_ready = 1'b1;
  logic [15:0] imem;
  logic [7:0]  wmem   [0:8];
  logic [7:0]  wmem_w [0:8];

  // Default instance
  logic [3:0]  ifmap_addr;
  logic        ifmap_data;
  logic [3:0]  weight_addr;
  logic [7:0]  weight_data;
  logic [11:0] pe_inpsum, pe_outpsum, out_psum;
  logic [7:0]  pe_weight, pe_bias;
  logic        pe_infmap, out_valid, busy, done;
  logic [1:0]  out_row, out_col;
  logic [2:0]  dbg_state;

  conv_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .ifmap_addr(ifmap_addr), .ifmap_data(ifmap_data),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .pe_inpsum(pe_inpsum), .pe_weight(pe_weight), .pe_bias(pe_bias),
    .pe_infmap(pe_infmap), .pe_outpsum(pe_outpsum),
    .out_psum(out_psum), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // 10-bit accumulator instance
  logic [3:0] ifmap_addr_w;
  logic       ifmap_data_w;
  logic [3:0] weight_addr_w;
  logic [7:0] weight_data_w;
  logic [9:0] pe_inpsum_w, pe_outpsum_w, out_psum_w;
  logic [7:0] pe_weight_w, pe_bias_w;
  logic       pe_infmap_w, out_valid_w, busy_w, done_w;
  logic [1:0] out_row_w, out_col_w;
  logic [2:0] dbg_state_w;

  conv_window_sequencer #(.PSUM_DATA_WIDTH(10)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .bias(bias),
    .ifmap_addr(ifmap_addr_w), .ifmap_data(ifmap_data_w),
    .weight_addr(weight_addr_w), .weight_data(weight_data_w),
    .pe_inpsum(pe_inpsum_w), .pe_weight(pe_weight_w), .pe_bias(pe_bias_w),
    .pe_infmap(pe_infmap_w), .pe_outpsum(pe_outpsum_w),
    .out_psum(out_psum_w), .out_row(out_row_w), .out_col(out_col_w),
    .out_valid(out_valid_w), .out_ready(1'b1),
    .busy(busy_w), .done(done_w), .dbg_state(dbg_state_w)
  );

  // Synchronous-read memories
  always @(posedge clk) begin
    ifmap_data    <= imem[ifmap_addr];
    weight_data   <= wmem[weight_addr];
    ifmap_data_w  <= imem[ifmap_addr_w];
    weight_data_w <= wmem_w[weight_addr_w];
  end

  // Binary PE: bit 1 contributes +w, bit 0 contributes -w; result truncates.
  int pe_s, pe_s_w;
  always_comb begin
    pe_s = int'($signed(pe_inpsum)) + int'($signed(pe_bias)) +
           (pe_infmap ? int'($signed(pe_weight)) : -int'($signed(pe_weight)));
    pe_outpsum = pe_s[11:0];
  end
  always_comb begin
    pe_s_w = int'($signed(pe_inpsum_w)) + int'($signed(pe_bias_w)) +
             (pe_infmap_w ? int'($signed(pe_weight_w)) : -int'($signed(pe_weight_w)));
    pe_outpsum_w = pe_s_w[9:0];
  end

  // Observations captured by run_pass
  int obs_psum [0:7];
  int obs_row  [0:7];
  int obs_col  [0:7];
  int n_out, done_cnt, first_valid_cyc, done_cyc, busy_after;

  // Starts a pass on the default instance and records handshakes; entered at a negedge.
  task automatic run_pass(input int max_cyc);
    n_out = 0; done_cnt = 0; first_valid_cyc = -1; done_cyc = -1; busy_after = -1;
    start = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready && n_out < 8) begin
        obs_psum[n_out] = int'($signed(out_psum));
        obs_row[n_out]  = int'(out_row);
        obs_col[n_out]  = int'(out_col);
        n_out++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        busy_after = int'(busy);
        break;
      end
    end
  endtask

  task automatic fill_mem(input int pattern, input logic [7:0] w);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        imem[r*4+c] = (pattern == 0) ? 1'b0 : (pattern == 1) ? 1'b1 : 1'(r + c);
    for (int i = 0; i < 9; i++) begin
      wmem[i]   = w;
      wmem_w[i] = 8'd127;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done, pe_bias, out_psum, out_row, out_col, ifmap_addr, weight_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b bias=%0d psum=%0d addr=%0d/%0d, want all 0",
               out_valid, busy, done, pe_bias, out_psum, ifmap_addr, weight_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got state=%0d busy=%b, want 0/0", dbg_state, busy);
    end
  endtask

  task automatic test_basic();
    fill_mem(1, 8'd1);
    bias = 8'd0;
    run_pass(100);
    n_cmp++;
    if (n_out !== 4) begin n_fail++; $display("FAIL basic_count: got %0d, want 4", n_out); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_psum[i] !== 9 || obs_row[i] !== i / 2 || obs_col[i] !== i % 2) begin
        n_fail++;
        $display("FAIL basic_out%0d: got psum=%0d (%0d,%0d), want 9 (%0d,%0d)",
                 i, obs_psum[i], obs_row[i], obs_col[i], i / 2, i % 2);
      end
    end
    n_cmp++;
    if (first_valid_cyc !== 11) begin n_fail++; $display("FAIL basic_latency: got %0d, want 11", first_valid_cyc); end
    n_cmp++;
    if (done_cyc !== 45) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, want 45", done_cyc); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, want 1", done_cnt); end
    n_cmp++;
    if (busy_after !== 0) begin n_fail++; $display("FAIL basic_busy_after: got %0d, want 0", busy_after); end
  endtask

  // Runs a full pass and checks the four window sums against hand-computed values.
  task automatic test_pattern(input int pattern, input logic [7:0] b,
                              input int e0, input int e1, input int e2, input int e3);
    int exp_v [0:3];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    fill_mem(pattern, 8'd1);
    bias = b;
    run_pass(100);
    n_cmp++;
    if (n_out !== 4 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL pattern%0d_count: got %0d outputs %0d dones, want 4/1", pattern, n_out, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_psum[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL pattern%0d_bias%0d_out%0d: got %0d, want %0d", pattern, b, i, obs_psum[i], exp_v[i]);
      end
    end
    bias = 8'd0;
  endtask

  task automatic test_stall();
    int seen, handshakes, dones;
    fill_mem(1, 8'd1);
    bias = 8'd0;
    out_ready = 1'b0;
    start = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen !== 1) begin n_fail++; $display("FAIL stall_first_valid: got %0d, want 1", seen); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || $signed(out_psum) !== 12'sd9 || out_row !== 2'd0 || out_col !== 2'd0 ||
          ifmap_addr !== 4'd0 || weight_addr !== 4'd0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b psum=%0d (%0d,%0d) addr=%0d/%0d, want 1 9 (0,0) 0/0",
                 i, out_valid, out_psum, out_row, out_col, ifmap_addr, weight_addr);
      end
    end
    out_ready = 1'b1;
    handshakes = 0;
    dones = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (out_valid && out_ready) handshakes++;
      @(negedge clk);
      if (done) begin dones++; break; end
    end
    n_cmp++;
    if (handshakes !== 4 || dones !== 1) begin
      n_fail++;
      $display("FAIL stall_total: got %0d outputs %0d dones, want 4/1", handshakes, dones);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int got, dones;
    fill_mem(1, 8'd1);
    bias = 8'd0;
    got = 0;
    dones = 0;
    start_w = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      start_w = 1'b0;
      if (out_valid_w) begin
        n_cmp++;
        if ($signed(out_psum_w) !== 10'sd119) begin
          n_fail++;
          $display("FAIL wrap_out%0d: got %0d, want 119", got, $signed(out_psum_w));
        end
        got++;
      end
      if (done_w) begin dones++; break; end
    end
    n_cmp++;
    if (got !== 4 || dones !== 1) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d outputs %0d dones, want 4/1", got, dones);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int hs;
    fill_mem(1, 8'd1);
    bias = 8'd3;
    start = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 40 && hs == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) hs = 1;
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 3'd1) begin n_fail++; $display("FAIL midrst_in_run: got state=%0d, want 1", dbg_state); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, done, pe_bias, out_psum, out_row, out_col, ifmap_addr, weight_addr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b busy=%b done=%b psum=%0d (%0d,%0d), want all 0",
               out_valid, busy, done, out_psum, out_row, out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bias = 8'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got busy=%b done=%b, want 0/0", busy, done);
    end
    run_pass(100);
    n_cmp++;
    if (n_out !== 4 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL midrst_rerun_count: got %0d outputs %0d dones, want 4/1", n_out, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_psum[i] !== 9 || obs_row[i] !== i / 2 || obs_col[i] !== i % 2) begin
        n_fail++;
        $display("FAIL midrst_rerun_out%0d: got psum=%0d (%0d,%0d), want 9 (%0d,%0d)",
                 i, obs_psum[i], obs_row[i], obs_col[i], i / 2, i % 2);
      end
    end
  endtask

  initial begin
    fill_mem(1, 8'd1);
    @(negedge clk);
    test_reset();
    test_basic();
    test_pattern(1, 8'd2, 11, 11, 11, 11);
    test_pattern(0, 8'd0, -9, -9, -9, -9);
    test_pattern(2, 8'd0, -1, 1, 1, -1);
    test_stall();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
